// File: rtl/cdr_pam_tx.sv
// Baud-rate PAM4/NRZ loopback transmitter for CDR bring-up: an NCO paces symbols from a
// PRBS7 or an external stream, maps them to levels and band-limits them with a slew filter.
module cdr_pam_tx #(
    parameter int         LEVEL     = 96,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       fcw,
    input  logic [1:0]        mode,
    input  logic [2:0]        slew,
    input  logic [1:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              underrun_clr,
    output logic signed [7:0] y_n,
    output logic [1:0]        sym,
    output logic              sym_strobe,
    output logic              underrun
);

    localparam logic signed [7:0]  OUTER   = 8'(LEVEL);
    localparam logic signed [7:0]  INNER   = 8'(LEVEL / 3);
    localparam logic signed [17:0] SAT_POS = 18'sd32512;
    localparam logic signed [17:0] SAT_NEG = -18'sd32512;

    logic [31:0]        phase;
    logic [32:0]        nco_sum;
    logic               tick;
    logic [6:0]         lfsr;
    logic [6:0]         lfsr_one;
    logic [6:0]         lfsr_two;
    logic [6:0]         lfsr_next;
    logic [1:0]         sym_next;
    logic               sym_load;
    logic               underrun_set;
    logic signed [7:0]  target;
    logic signed [15:0] y_acc;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [17:0] acc_sum;
    logic signed [15:0] acc_next;

    assign nco_sum = {1'b0, phase} + {1'b0, fcw};
    assign tick    = en & nco_sum[32];
    assign s_ready = tick & mode[1] & ~rst;

    assign lfsr_one = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    assign lfsr_two = {lfsr_one[5:0], lfsr_one[6] ^ lfsr_one[5]};

    // Gray-coded PAM4: adjacent levels differ in one bit, so 10 is the top level.
    function automatic logic signed [7:0] level_of(input logic [1:0] code);
        case (code)
            2'b00:   level_of = -OUTER;
            2'b01:   level_of = -INNER;
            2'b11:   level_of = INNER;
            default: level_of = OUTER;
        endcase
    endfunction

    always_comb begin
        sym_next     = sym;
        lfsr_next    = lfsr;
        sym_load     = 1'b0;
        underrun_set = 1'b0;
        if (tick) begin
            case (mode)
                2'b00: begin
                    sym_next  = {lfsr[6], 1'b0};
                    lfsr_next = lfsr_one;
                    sym_load  = 1'b1;
                end
                2'b01: begin
                    sym_next  = {lfsr[6], lfsr[5]};
                    lfsr_next = lfsr_two;
                    sym_load  = 1'b1;
                end
                default: begin
                    if (s_valid) begin
                        sym_next = mode[0] ? s_data : {s_data[0], 1'b0};
                        sym_load = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            endcase
        end
    end

    // First-order low-pass in Q8.8; the shift sets the channel bandwidth.
    always_comb begin
        diff    = {target[7], target, 8'h00} - {y_acc[15], y_acc};
        step    = diff >>> slew;
        acc_sum = {step[16], step} + {{2{y_acc[15]}}, y_acc};
        if (acc_sum > SAT_POS) begin
            acc_next = 16'(SAT_POS);
        end else if (acc_sum < SAT_NEG) begin
            acc_next = 16'(SAT_NEG);
        end else begin
            acc_next = acc_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            lfsr       <= PRBS_SEED;
            sym        <= '0;
            target     <= '0;
            y_acc      <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (en) begin
                phase <= nco_sum[31:0];
            end
            lfsr       <= lfsr_next;
            sym        <= sym_next;
            sym_strobe <= tick;
            if (sym_load) begin
                target <= level_of(sym_next);
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            y_acc <= acc_next;
        end
    end

    assign y_n = y_acc[15:8];

endmodule

// File: tb/tb_cdr_pam_tx.sv
// Randomised and directed bench for cdr_pam_tx, checked against a behavioural model built
// from the PRBS bit sequence, phase arithmetic and the level table.
module tb_cdr_pam_tx;

    localparam int LEVEL = 96;
    localparam logic [6:0] SEED = 7'h7F;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [31:0]       fcw = '0;
    logic [1:0]        mode = '0;
    logic [2:0]        slew = '0;
    logic [1:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              underrun_clr = 1'b0;
    logic              s_ready;
    logic signed [7:0] y_n;
    logic [1:0]        sym;
    logic              sym_strobe;
    logic              underrun;

    int checkCount = 0;
    int errorCount = 0;

    bit              prbs [0:126];
    longint unsigned mPhase = 0;
    int              mPos = 0;
    logic [1:0]      mSym = 0;
    int              mTarget = 0;
    int              mAcc = 0;
    bit              mStrobe = 0;
    bit              mUnder = 0;
    bit              mTick = 0;

    cdr_pam_tx #(.LEVEL(LEVEL), .PRBS_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .fcw(fcw), .mode(mode), .slew(slew),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .underrun_clr(underrun_clr), .y_n(y_n), .sym(sym),
        .sym_strobe(sym_strobe), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic int levelOf(input logic [1:0] code);
        case (code)
            2'b00:   return -LEVEL;
            2'b01:   return -(LEVEL / 3);
            2'b11:   return LEVEL / 3;
            default: return LEVEL;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus; the model advances at the edge and all outputs are compared.
    task automatic applyStimulus(input bit r, input bit e, input logic [31:0] f,
                                 input logic [1:0] m, input logic [2:0] sl,
                                 input logic [1:0] sd, input bit sv, input bit uc);
        longint unsigned sum;
        bit tick;
        int diff;
        int nacc;
        @(negedge clk);
        rst = r; en = e; fcw = f; mode = m; slew = sl;
        s_data = sd; s_valid = sv; underrun_clr = uc;
        #1;
        sum  = mPhase + longint'(f);
        tick = e && (sum >= 64'h1_0000_0000);
        checkOutput("s_ready", int'(s_ready), int'(tick && m[1] && !r));
        @(posedge clk);
        if (r) begin
            mPhase = 0; mPos = 0; mSym = 0; mTarget = 0; mAcc = 0;
            mStrobe = 0; mUnder = 0; mTick = 0;
        end else begin
            diff = mTarget * 256 - mAcc;
            nacc = mAcc + (diff >>> sl);
            if (nacc > 32512) nacc = 32512;
            if (nacc < -32512) nacc = -32512;
            mAcc = nacc;
            if (e) mPhase = sum % 64'h1_0000_0000;
            mStrobe = tick;
            mTick = tick;
            if (tick && m == 2'b00) begin
                mSym = {prbs[mPos], 1'b0};
                mPos = (mPos + 1) % 127;
                mTarget = levelOf(mSym);
            end else if (tick && m == 2'b01) begin
                mSym = {prbs[mPos], prbs[(mPos + 1) % 127]};
                mPos = (mPos + 2) % 127;
                mTarget = levelOf(mSym);
            end else if (tick && sv) begin
                mSym = m[0] ? sd : {sd[0], 1'b0};
                mTarget = levelOf(mSym);
            end
            if (tick && m[1] && !sv) mUnder = 1;
            else if (uc) mUnder = 0;
        end
        #1;
        checkOutput("y_n", int'(y_n), mAcc >>> 8);
        checkOutput("sym", int'(sym), int'(mSym));
        checkOutput("sym_strobe", int'(sym_strobe), int'(mStrobe));
        checkOutput("underrun", int'(underrun), int'(mUnder));
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 32'h4000_0000, 2'b00, 3'd0, 2'b00, 1, 0);
    endtask

    initial begin
        int strobes;
        int highCount;
        int yVals [4];
        int yIdx;
        int dIdx;
        bit pend;
        bit seenFirst;
        int prevY;
        int firstStep;
        int violations;
        int settle;
        bit rising;
        logic [1:0] seq [4];
        logic [31:0] rf;
        logic [1:0] rm;
        logic [2:0] rs;

        for (int i = 0; i < 7; i++) prbs[i] = SEED[6 - i];
        for (int i = 7; i < 127; i++) prbs[i] = prbs[i - 7] ^ prbs[i - 6];

        // PRBS NRZ: strobe every 4 cycles, seed gives seven leading ones
        resetCycles(2);
        checkOutput("reset_y_n", int'(y_n), 0);
        checkOutput("reset_sym", int'(sym), 0);
        strobes = 0; highCount = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 32'h4000_0000, 2'b00, 3'd0, 2'b00, 0, 0);
            if (sym_strobe) begin
                strobes++;
                if (strobes <= 7 && sym == 2'b10) highCount++;
            end
        end
        checkOutput("nrz_strobe_count", strobes, 10);
        checkOutput("nrz_first7_high", highCount, 7);
        for (int i = 0; i < 560; i++) applyStimulus(0, 1, 32'h4000_0000, 2'b00, 3'd0, 2'b00, 0, 0);

        // PRBS PAM4 from reset: first symbol 11 -> +LEVEL/3
        resetCycles(1);
        seenFirst = 0; pend = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 1, 32'h8000_0000, 2'b01, 3'd0, 2'b00, 0, 0);
            if (pend) begin
                checkOutput("pam4_first_y", int'(y_n), 32);
                pend = 0;
            end
            if (sym_strobe && !seenFirst) begin
                checkOutput("pam4_first_sym", int'(sym), 3);
                seenFirst = 1; pend = 1;
            end
        end
        checkOutput("pam4_seen_strobe", int'(seenFirst), 1);

        // External PAM4 stream, one symbol per s_ready
        resetCycles(1);
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        dIdx = 0; yIdx = 0; pend = 0;
        for (int i = 0; i < 4; i++) yVals[i] = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, 1, 32'h4000_0000, 2'b11, 3'd0, seq[dIdx % 4], 1, 0);
            if (mTick) dIdx++;
            if (pend && yIdx < 4) begin
                yVals[yIdx] = int'(y_n);
                yIdx++;
            end
            pend = sym_strobe;
        end
        checkOutput("ext_pam4_y0", yVals[0], -96);
        checkOutput("ext_pam4_y1", yVals[1], -32);
        checkOutput("ext_pam4_y2", yVals[2], 32);
        checkOutput("ext_pam4_y3", yVals[3], 96);

        // Underrun set, clear, and set winning over clear
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 0, 0);
        checkOutput("underrun_set", int'(underrun), 1);
        checkOutput("underrun_hold_y", int'(y_n), 96);
        for (int i = 0; i < 8 && (mPhase + 64'h4000_0000) >= 64'h1_0000_0000; i++)
            applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 1, 0);
        applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 1, 1);
        checkOutput("underrun_clear", int'(underrun), 0);
        for (int i = 0; i < 8 && (mPhase + 64'h4000_0000) < 64'h1_0000_0000; i++)
            applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 1, 0);
        applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd0, 2'b01, 0, 1);
        checkOutput("underrun_set_over_clr", int'(underrun), 1);

        // Slew filter step response from -96 to +96
        for (int i = 0; i < 60; i++) applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd2, 2'b00, 1, 1);
        checkOutput("slew_low_level", int'(y_n), -96);
        prevY = int'(y_n); firstStep = 0; violations = 0; settle = 0; rising = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(0, 1, 32'h4000_0000, 2'b10, 3'd2, 2'b01, 1, 0);
            if (int'(y_n) < prevY) violations++;
            if (firstStep == 0 && int'(y_n) != prevY) firstStep = int'(y_n);
            if (rising && int'(y_n) < 95) settle++;
            if (sym_strobe && sym == 2'b10) rising = 1;
            prevY = int'(y_n);
        end
        checkOutput("slew_monotonic", violations, 0);
        checkOutput("slew_first_step", firstStep, -48);
        checkOutput("slew_settle_ok", int'(settle <= 30), 1);
        checkOutput("slew_final_near", int'(int'(y_n) >= 95), 1);

        // fcw=0 and en=0 never strobe
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 32'h0, 2'b00, 3'd1, 2'b00, 0, 0);
            strobes += int'(sym_strobe);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 32'h8000_0000, 2'b11, 3'd1, 2'b00, 1, 0);
            strobes += int'(sym_strobe);
        end
        checkOutput("no_strobe_idle", strobes, 0);

        // Mid-stream reset restarts the PRBS from the seed
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 32'h4000_0000, 2'b00, 3'd0, 2'b00, 0, 0);
        resetCycles(1);
        checkOutput("midrst_y_n", int'(y_n), 0);
        checkOutput("midrst_strobe", int'(sym_strobe), 0);
        strobes = 0; highCount = 0;
        for (int i = 0; i < 28; i++) begin
            applyStimulus(0, 1, 32'h4000_0000, 2'b00, 3'd0, 2'b00, 0, 0);
            if (sym_strobe) begin
                strobes++;
                if (sym == 2'b10) highCount++;
            end
        end
        checkOutput("midrst_first7_high", highCount, 7);

        // Random operation against the model
        rf = 32'h4000_0000; rm = 2'b00; rs = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 4))
                    0: rf = 32'h4000_0000;
                    1: rf = 32'h8000_0000;
                    2: rf = $urandom;
                    3: rf = $urandom >> 2;
                    default: rf = 32'h0;
                endcase
                rm = 2'($urandom_range(0, 3));
                rs = 3'($urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, rf, rm, rs,
                          2'($urandom_range(0, 3)), $urandom_range(0, 6) != 0,
                          $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
